dense_operand_streamer: RTL and testbench

- Producer end of the dense-layer operand stream. Holds one activation vector, one weight matrix and one bias vector, loaded through a write port.
- On start, emits (input, weight, bias) triples over a valid/ready stream, neuron by neuron, into the MAC/bias/sigmoid datapath.
- Replaces free-running counter stimulus with addressed, back-pressurable operand delivery.

---
 rtl/dense_operand_streamer.sv | 195 +++++++++++++++++++
 tb/tb_dense_operand_streamer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_operand_streamer.sv
`default_nettype none
// ============================================================================
// Module   : dense_operand_streamer
// Purpose  : Producer end of the dense-layer operand stream. Holds one
//            activation vector x[N_IN], one weight matrix W[N_OUT][N_IN] and
//            one bias vector b[N_OUT], loaded through a write port. On start,
//            emits (x[idx], W[n][idx], b[n]) beats over a valid/ready stream,
//            neuron by neuron, idx 0..N_IN-1 within each neuron.
// Ports    : clk, rst (async, active-high)
//            wr_en/wr_sel/wr_addr/wr_data : load port (sel 0=x, 1=W, 2=b)
//            wr_err                       : one-cycle pulse, load rejected
//            start/busy/done              : pass control and status
//            m_valid/m_ready              : output handshake
//            m_input/m_weight/m_bias/m_neuron/m_first/m_last : beat payload
// Options  : STREAMER_ZERO_SKIP_EN - suppress beats whose input word is zero,
//            except the last beat of each neuron.
// Revision : 1.0 - initial release
// ============================================================================
module dense_operand_streamer #(
    parameter  int DATA_W = 8,
    parameter  int N_IN   = 64,
    parameter  int N_OUT  = 16,
    parameter  int ADDR_W = $clog2(N_IN*N_OUT),
    localparam int NW     = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wr_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_input,
    output logic [DATA_W-1:0] m_weight,
    output logic [DATA_W-1:0] m_bias,
    output logic [NW-1:0]     m_neuron,
    output logic              m_first,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_x [N_IN];
    logic [DATA_W-1:0] r_w [N_IN*N_OUT];
    logic [DATA_W-1:0] r_b [N_OUT];

    // Issue pointer: next candidate beat to read into the output register.
    logic [IW-1:0]     r_idx;
    logic [NW-1:0]     r_neu;
    logic              r_nstart;

    logic [IW-1:0]     w_sel_idx;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_wr_range;
    logic              w_wr_ok;
    logic              w_sel_last;
    logic              w_last_neu;
    logic              w_can_load;

    // ------------------------------------------------------------------
    // Load port
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_range = 1'b0;
        case (wr_sel)
            2'd0:    w_wr_range = (32'(wr_addr) < N_IN);
            2'd1:    w_wr_range = (32'(wr_addr) < N_IN*N_OUT);
            2'd2:    w_wr_range = (32'(wr_addr) < N_OUT);
            default: w_wr_range = 1'b0;
        endcase
    end

    assign w_wr_ok = wr_en && !busy && w_wr_range;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            case (wr_sel)
                2'd0:    r_x[wr_addr[IW-1:0]] <= wr_data;
                2'd1:    r_w[wr_addr]         <= wr_data;
                2'd2:    r_b[wr_addr[NW-1:0]] <= wr_data;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat selection
    // ------------------------------------------------------------------
`ifdef STREAMER_ZERO_SKIP_EN
    // Lowest idx >= r_idx with a non-zero input; the last idx is always a
    // candidate so every neuron still closes with an m_last beat. Searching
    // ahead combinationally means skipped beats cost no output cycles.
    always_comb begin
        w_sel_idx = IW'(N_IN-1);
        for (int i = N_IN-2; i >= 0; i--) begin
            if ((i >= int'(r_idx)) && (r_x[i] != '0)) begin
                w_sel_idx = IW'(i);
            end
        end
    end
`else
    assign w_sel_idx = r_idx;
`endif

    assign w_waddr    = ADDR_W'(r_neu) * ADDR_W'(N_IN) + ADDR_W'(w_sel_idx);
    assign w_sel_last = (w_sel_idx == IW'(N_IN-1));
    assign w_last_neu = (r_neu == NW'(N_OUT-1));

    // The output register doubles as the synchronous read register; it is
    // refilled only when empty or being consumed, so stalls hold it stable.
    assign w_can_load = !m_valid || m_ready;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_neu    <= '0;
            r_nstart <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
            m_valid  <= 1'b0;
            m_input  <= '0;
            m_weight <= '0;
            m_bias   <= '0;
            m_neuron <= '0;
            m_first  <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            done   <= 1'b0;
            wr_err <= wr_en && !w_wr_ok;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_STREAM;
                        busy     <= 1'b1;
                        r_idx    <= '0;
                        r_neu    <= '0;
                        r_nstart <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_can_load) begin
                        m_valid  <= 1'b1;
                        m_input  <= r_x[w_sel_idx];
                        m_weight <= r_w[w_waddr];
                        m_bias   <= r_b[r_neu];
                        m_neuron <= r_neu;
                        m_first  <= r_nstart;
                        m_last   <= w_sel_last;
                        r_nstart <= 1'b0;
                        if (w_sel_last) begin
                            if (w_last_neu) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_neu    <= r_neu + 1'b1;
                                r_idx    <= '0;
                                r_nstart <= 1'b1;
                            end
                        end else begin
                            r_idx <= w_sel_idx + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_first <= 1'b0;
                        m_last  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dense_operand_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_operand_streamer
// Purpose  : Self-checking bench for dense_operand_streamer (N_IN=4, N_OUT=2).
//            A reference model builds the expected beat list from the loaded
//            memory image; one negedge process checks every handshake, stall
//            stability and the done pulse. Literal tables pin the model.
// Options  : STREAMER_ZERO_SKIP_EN - model and scenario for zero skipping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_operand_streamer;

    localparam int DATA_W = 8;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int ADDR_W = 3;
    localparam int NW     = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_sel = '0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              m_ready = 1'b1;
    logic              busy, done, wr_err, m_valid, m_first, m_last;
    logic [DATA_W-1:0] m_input, m_weight, m_bias;
    logic [NW-1:0]     m_neuron;

    dense_operand_streamer #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .wr_err(wr_err), .m_valid(m_valid), .m_ready(m_ready),
        .m_input(m_input), .m_weight(m_weight), .m_bias(m_bias),
        .m_neuron(m_neuron), .m_first(m_first), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int inp; int wt; int bs; int neu; bit first; bit last;
    } beat_t;

    int    mx [N_IN];
    int    mw [N_IN*N_OUT];
    int    mb [N_OUT];
    beat_t exp_q [$];
    beat_t cap [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    hs_cnt = 0;
    int    done_cnt = 0;
    int    rmode = 0;
    int    rcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected beats for one pass, straight from the memory image.
    task automatic build_exp();
        exp_q.delete();
        cap.delete();
        hs_cnt = 0;
        for (int n = 0; n < N_OUT; n++) begin
            bit f = 1'b1;
            for (int i = 0; i < N_IN; i++) begin
                bit emit = 1'b1;
`ifdef STREAMER_ZERO_SKIP_EN
                emit = (mx[i] != 0) || (i == N_IN-1);
`endif
                if (emit) begin
                    exp_q.push_back('{mx[i], mw[n*N_IN+i], mb[n], n, f, (i == N_IN-1)});
                    f = 1'b0;
                end
            end
        end
    endtask

    // Consumer ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3); rcnt++; end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Compare process.
    bit    pend_done = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev;
    always @(negedge clk) begin
        if (rst) begin
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done_pulse", done, pend_done);
            if (done) begin
                chk("busy_at_done", busy, 0);
                done_cnt++;
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_input", m_input, prev.inp);
                chk("stall_weight", m_weight, prev.wt);
                chk("stall_bias", m_bias, prev.bs);
                chk("stall_neuron", m_neuron, prev.neu);
                chk("stall_first", m_first, prev.first);
                chk("stall_last", m_last, prev.last);
            end
            pend_done = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got input %0d weight %0d required no beat", m_input, m_weight);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_input", m_input, e.inp);
                    chk("beat_weight", m_weight, e.wt);
                    chk("beat_bias", m_bias, e.bs);
                    chk("beat_neuron", m_neuron, e.neu);
                    chk("beat_first", m_first, e.first);
                    chk("beat_last", m_last, e.last);
                    cap.push_back('{int'(m_input), int'(m_weight), int'(m_bias),
                                   int'(m_neuron), m_first, m_last});
                    hs_cnt++;
                    if (exp_q.size() == 0) pend_done = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev = '{int'(m_input), int'(m_weight), int'(m_bias), int'(m_neuron), m_first, m_last};
        end
    end

    function automatic bit wr_illegal(input int sel, input int addr);
        case (sel)
            0:       return addr >= N_IN;
            1:       return addr >= N_IN*N_OUT;
            2:       return addr >= N_OUT;
            default: return 1'b1;
        endcase
    endfunction

    task automatic do_write(input int sel, input int addr, input int data, input bit in_pass);
        bit e;
        e = in_pass || wr_illegal(sel, addr);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = 2'(sel); wr_addr = ADDR_W'(addr); wr_data = DATA_W'(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("wr_err", wr_err, e);
        if (!e) begin
            case (sel)
                0:       mx[addr] = data;
                1:       mw[addr] = data;
                default: mb[addr] = data;
            endcase
        end
        @(negedge clk);
        chk("wr_err_pulse", wr_err, 0);
    endtask

    task automatic load_all(input int x0, input int x1, input int x2, input int x3);
        int xs [N_IN];
        xs = '{x0, x1, x2, x3};
        for (int i = 0; i < N_IN; i++) do_write(0, i, xs[i], 1'b0);
        for (int n = 0; n < N_OUT; n++)
            for (int i = 0; i < N_IN; i++) do_write(1, n*N_IN + i, 10*n + i, 1'b0);
        do_write(2, 0, 7, 1'b0);
        do_write(2, 1, 9, 1'b0);
    endtask

    // Start a pass, optionally with a same-cycle write; checks the start latency.
    task automatic start_pass(input bit with_wr, input int sel, input int addr, input int data);
        @(posedge clk); #1;
        if (with_wr) begin
            wr_en = 1'b1; wr_sel = 2'(sel); wr_addr = ADDR_W'(addr); wr_data = DATA_W'(data);
            if (sel == 0) mx[addr] = data;
            else if (sel == 1) mw[addr] = data;
            else mb[addr] = data;
        end
        build_exp();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("valid_at_T1", m_valid, 0);
        if (with_wr) chk("wr_err_with_start", wr_err, 0);
        @(negedge clk);
        chk("valid_at_T2", m_valid, 1);
    endtask

    // Wait for the done pulse; optionally pulse start during the final handshake.
    task automatic wait_done(input bit start_on_last);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge clk);
            if (start_on_last && m_valid && m_ready && m_last && (m_neuron == NW'(N_OUT-1)))
                start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        if (done_cnt == d0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", k);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_cnt, d0 + 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("idle_after_pass", busy, 0);
    endtask

    task automatic check_s1_literals();
        chk("s1_count", cap.size(), 8);
        if (cap.size() == 8) begin
            chk("s1_b0_in", cap[0].inp, 1);   chk("s1_b0_w", cap[0].wt, 0);
            chk("s1_b0_b", cap[0].bs, 7);     chk("s1_b0_first", cap[0].first, 1);
            chk("s1_b3_in", cap[3].inp, 4);   chk("s1_b3_last", cap[3].last, 1);
            chk("s1_b4_w", cap[4].wt, 10);    chk("s1_b4_b", cap[4].bs, 9);
            chk("s1_b4_first", cap[4].first, 1);
            chk("s1_b7_w", cap[7].wt, 13);    chk("s1_b7_last", cap[7].last, 1);
            chk("s1_b6_in", cap[6].inp, 3);   chk("s1_b6_flags", {cap[6].first, cap[6].last}, 0);
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_wr_err", wr_err, 0); chk("rst_valid", m_valid, 0);
        chk("rst_first", m_first, 0); chk("rst_last", m_last, 0);
        chk("rst_input", m_input, 0); chk("rst_weight", m_weight, 0);
        chk("rst_bias", m_bias, 0);   chk("rst_neuron", m_neuron, 0);
        #20 rst = 1'b0;

        // 1. back-to-back pass
        load_all(1, 2, 3, 4);
        rmode = 0;
        start_pass(1'b0, 0, 0, 0);
        wait_done(1'b0);
        check_s1_literals();

        // 2. ready pattern 1,0,0,1
        rmode = 1; rcnt = 0;
        start_pass(1'b0, 0, 0, 0);
        wait_done(1'b0);
        check_s1_literals();

        // 3. rejected loads: write during busy, out of range, reserved select
        rmode = 0;
        start_pass(1'b0, 0, 0, 0);
        do_write(0, 0, 8'hAA, 1'b1);
        wait_done(1'b0);
        do_write(0, 4, 8'h55, 1'b0);
        do_write(2, 2, 8'h55, 1'b0);
        do_write(3, 0, 8'h55, 1'b0);
        start_pass(1'b0, 0, 0, 0);
        wait_done(1'b0);
        check_s1_literals();

        // 4. reset after the 3rd handshake
        start_pass(1'b0, 0, 0, 0);
        for (int k = 0; k < 50 && hs_cnt < 3; k++) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, done_cnt);
        start_pass(1'b0, 0, 0, 0);
        wait_done(1'b0);
        check_s1_literals();

        // 5. start while busy and start on the final handshake
        start_pass(1'b0, 0, 0, 0);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(1'b1);
        chk("s5_valid_after", m_valid, 0);

        // 5b. write in the same cycle as start: pass sees the new data
        start_pass(1'b1, 1, 5, 77);
        wait_done(1'b0);
        chk("s5b_cap_size", cap.size(), 8);
        if (cap.size() == 8) chk("s5b_new_weight", cap[5].wt, 77);
        do_write(1, 5, 11, 1'b0);

`ifdef STREAMER_ZERO_SKIP_EN
        // 6. zero skipping, x=[0,2,0,0]
        do_write(0, 0, 0, 1'b0);
        do_write(0, 2, 0, 1'b0);
        do_write(0, 3, 0, 1'b0);
        rmode = 2;
        start_pass(1'b0, 0, 0, 0);
        wait_done(1'b0);
        chk("s6_count", cap.size(), 4);
        if (cap.size() == 4) begin
            chk("s6_b0_in", cap[0].inp, 2);  chk("s6_b0_w", cap[0].wt, 1);
            chk("s6_b0_first", cap[0].first, 1); chk("s6_b0_last", cap[0].last, 0);
            chk("s6_b1_in", cap[1].inp, 0);  chk("s6_b1_w", cap[1].wt, 3);
            chk("s6_b1_first", cap[1].first, 0); chk("s6_b1_last", cap[1].last, 1);
            chk("s6_b2_w", cap[2].wt, 11);   chk("s6_b2_first", cap[2].first, 1);
            chk("s6_b3_w", cap[3].wt, 13);   chk("s6_b3_last", cap[3].last, 1);
        end
`endif

        // Random contents, random writes (some illegal), random backpressure.
        rmode = 2;
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 14; j++) begin
                int sel  = $urandom_range(0, 3);
                int addr = $urandom_range(0, 7);
                int data = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 255);
                do_write(sel, addr, data, 1'b0);
            end
            start_pass(1'b0, 0, 0, 0);
            if (p % 2 == 1) do_write(2, 0, 3, 1'b1);
            wait_done(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
